draw_scheduler: RTL and testbench



---
 rtl/draw_scheduler.sv | 161 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Shares one VGA plot port among N_REQ rectangle requesters, scanning the granted rectangle one pixel per clock.
// Round-robin by default; define DRAW_SCHED_FIXED_PRIORITY_EN for fixed priority (lowest index wins).
module draw_scheduler #(
    parameter int N_REQ = 4,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_x,
    input  logic [7*N_REQ-1:0] req_y,
    input  logic [8*N_REQ-1:0] req_w,
    input  logic [7*N_REQ-1:0] req_h,
    input  logic [3*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic               busy,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         colour,
    output logic               plot
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [8:0] XM = 9'(X_MAX);
    localparam logic [7:0] YM = 8'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_win;
    logic [IW-1:0]    w_win;
    logic [7:0]       r_x0;
    logic [7:0]       r_w;
    logic [7:0]       r_cx;
    logic [6:0]       r_y0;
    logic [6:0]       r_h;
    logic [6:0]       r_cy;
    logic [2:0]       r_col;
    logic [N_REQ-1:0] r_ack;

    logic [7:0] w_sel_w;
    logic [6:0] w_sel_h;
    logic       w_any;
    logic       w_last_x;
    logic       w_last_y;
    logic       w_fin;
    logic [8:0] w_sx;
    logic [7:0] w_sy;

    assign w_any    = |req;
    assign w_sel_w  = req_w[int'(w_win)*8 +: 8];
    assign w_sel_h  = req_h[int'(w_win)*7 +: 7];
    assign w_last_x = (r_cx == r_w - 8'd1);
    assign w_last_y = (r_cy == r_h - 7'd1);
    assign w_sx     = {1'b0, r_x0} + {1'b0, r_cx};
    assign w_sy     = {1'b0, r_y0} + {1'b0, r_cy};
    // An empty rectangle enters DONE together with its ack; done waits one cycle so the two never coincide.
    assign w_fin    = (r_state == S_DONE) && !(|r_ack);

`ifdef DRAW_SCHED_FIXED_PRIORITY_EN
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = IW'(i);
        end
    end
`else
    logic [IW-1:0] r_ptr;

    // Scan downward so the requester nearest r_ptr (in rotation order) is written last and wins.
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % N_REQ]) w_win = IW'((int'(r_ptr) + i) % N_REQ);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_fin) begin
            r_ptr <= IW'((int'(r_win) + 1) % N_REQ);
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_next = (w_sel_w != 8'd0 && w_sel_h != 7'd0) ? S_DRAW : S_DONE;
            S_DRAW: if (w_last_x && w_last_y) w_next = S_DONE;
            S_DONE: if (!(|r_ack)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != S_IDLE);
        ack    = r_ack;
        done   = w_fin ? (N_REQ'(1) << r_win) : '0;
        x      = '0;
        y      = '0;
        colour = '0;
        plot   = 1'b0;
        if (r_state == S_DRAW) begin
            x      = w_sx[7:0];
            y      = w_sy[6:0];
            colour = r_col;
            plot   = (w_sx < XM) && (w_sy < YM);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_win <= '0;
            r_x0  <= '0;
            r_y0  <= '0;
            r_w   <= '0;
            r_h   <= '0;
            r_col <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
            r_ack <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    r_cx <= '0;
                    r_cy <= '0;
                    if (w_any) begin
                        r_win <= w_win;
                        r_x0  <= req_x[int'(w_win)*8 +: 8];
                        r_y0  <= req_y[int'(w_win)*7 +: 7];
                        r_w   <= w_sel_w;
                        r_h   <= w_sel_h;
                        r_col <= req_colour[int'(w_win)*3 +: 3];
                        r_ack <= N_REQ'(1) << w_win;
                    end
                end
                S_DRAW: begin
                    if (w_last_x) begin
                        r_cx <= '0;
                        if (!w_last_y) r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler (default round-robin build).
module tb_draw_scheduler;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_x = '0;
    logic [27:0] req_y = '0;
    logic [31:0] req_w = '0;
    logic [27:0] req_h = '0;
    logic [11:0] req_colour = '0;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        busy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    draw_scheduler dut (
        .clock(clock), .resetn(resetn), .req(req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_colour(req_colour), .ack(ack), .done(done), .busy(busy),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_rq(input int i, input int px, input int py, input int pw, input int ph, input int pc);
        req_x[i*8 +: 8]      = 8'(px);
        req_y[i*7 +: 7]      = 7'(py);
        req_w[i*8 +: 8]      = 8'(pw);
        req_h[i*7 +: 7]      = 7'(ph);
        req_colour[i*3 +: 3] = 3'(pc);
        req[i]               = 1'b1;
    endtask

    task automatic do_reset();
        req    = '0;
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output logic [3:0] a);
        a = '0;
        for (int k = 0; k < 40 && a == 4'd0; k++) begin
            @(negedge clock);
            a = ack;
        end
        if (a == 4'd0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] pm;
        int got[$];
        int plots;
        int lat;

        // reset state
        @(negedge clock);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_xyc", {17'd0, x, y}, {8'd0, colour, 21'd0});
        resetn = 1'b1;
        @(negedge clock);

        // single request: requester 1, 3x2 at (10,20), colour 100
        set_rq(1, 10, 20, 3, 2, 4);
        @(negedge clock);
        chk("t1_ack", 32'(ack), 32'd2);
        req[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("t1_x", 32'(x), 32'(10 + k % 3));
            chk("t1_y", 32'(y), 32'(20 + k / 3));
            chk("t1_plot", 32'(plot), 32'd1);
            chk("t1_col", 32'(colour), 32'd4);
            chk("t1_nodone", 32'(done), 32'd0);
            @(negedge clock);
        end
        chk("t1_done", 32'(done), 32'd2);
        chk("t1_plot_off", 32'(plot), 32'd0);
        @(negedge clock);
        chk("t1_idle", 32'(busy), 32'd0);

        // contention: all four requesting, round-robin from ptr 0
        do_reset();
        for (int i = 0; i < 4; i++) set_rq(i, i, i, 1, 1, i);
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            @(negedge clock);
            if (ack != 4'd0) begin
                chk("t2_onehot", 32'($countones(ack)), 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) begin
                        got.push_back(i);
                        req[i] = 1'b0;
                    end
                end
            end
        end
        chk("t2_count", 32'(got.size()), 32'd4);
        foreach (got[i]) chk("t2_order", 32'(got[i]), 32'(i));
        repeat (3) @(negedge clock);

        // clipping at the bottom-right corner
        set_rq(0, 158, 119, 4, 2, 5);
        @(negedge clock);
        chk("t3_ack", 32'(ack), 32'd1);
        req[0] = 1'b0;
        pm = 8'b0000_0011;
        for (int k = 0; k < 8; k++) begin
            chk("t3_plot", 32'(plot), 32'(pm[k]));
            chk("t3_x", 32'(x), 32'((158 + k % 4) & 255));
            chk("t3_y", 32'(y), 32'((119 + k / 4) & 127));
            @(negedge clock);
        end
        chk("t3_done", 32'(done), 32'd1);
        @(negedge clock);

        // empty rectangle on requester 3 (ptr is 1, so 3 is found)
        set_rq(3, 5, 5, 0, 5, 7);
        @(negedge clock);
        chk("t4_ack", 32'(ack), 32'd8);
        chk("t4_nodone", 32'(done), 32'd0);
        chk("t4_plot0", 32'(plot), 32'd0);
        req[3] = 1'b0;
        @(negedge clock);
        chk("t4_done", 32'(done), 32'd8);
        chk("t4_noack", 32'(ack), 32'd0);
        chk("t4_plot1", 32'(plot), 32'd0);
        @(negedge clock);
        chk("t4_idle", 32'(busy), 32'd0);

        // move ptr to 3 with a 1x1 draw on requester 2
        set_rq(2, 1, 1, 1, 1, 1);
        @(negedge clock);
        chk("t5_pre_ack", 32'(ack), 32'd4);
        req[2] = 1'b0;
        repeat (3) @(negedge clock);

        // reset abort during pixel 3 of a 4x4, then ptr must restart at 0
        set_rq(0, 0, 0, 4, 4, 6);
        @(negedge clock);
        chk("t5_ack0", 32'(ack), 32'd1);
        req[0] = 1'b0;
        set_rq(2, 30, 30, 1, 1, 2);
        set_rq(3, 40, 40, 1, 1, 3);
        repeat (3) @(negedge clock);
        chk("t5_px3", {23'd0, plot, x}, {23'd0, 1'b1, 8'd3});
        resetn = 1'b0;
        #1;
        chk("t5_rst_plot", 32'(plot), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_xyc", {19'd0, x, y, colour}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("t5_ack2", 32'(ack), 32'd4);
        chk("t5_nodone", 32'(done), 32'd0);
        req[2] = 1'b0;
        wait_ack("t5_ack3", a);
        chk("t5_ack3", 32'(a), 32'd8);
        req[3] = 1'b0;
        repeat (3) @(negedge clock);

        // full-screen clear
        set_rq(1, 0, 0, 160, 120, 7);
        @(negedge clock);
        chk("t6_ack", 32'(ack), 32'd2);
        req[1] = 1'b0;
        plots = 0;
        lat   = -1;
        for (int c = 0; c < 20000; c++) begin
            if (plot) plots++;
            if (done != 4'd0) begin
                lat = c;
                break;
            end
            @(negedge clock);
        end
        chk("t6_plots", 32'(plots), 32'd19200);
        chk("t6_done_lat", 32'(lat), 32'd19200);
        chk("t6_done_id", 32'(done), 32'd2);
        @(negedge clock);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
